pc_fetch_unit: RTL and testbench

Instruction-fetch front end that consumes the redirect outputs of the ID-stage branch logic and drives the instruction-memory request port. Owns the architectural fetch PC and the IF/ID pipeline register: it issues one fetch at a time, tags each returned instruction with its PC, and holds it under ID stall using a one-entry skid buffer. On a taken branch it flushes in-flight and buffered instructions and restarts fetch at the selected target.

---
 rtl/pc_fetch_unit_if.sv | 38 +++
 rtl/pc_fetch_unit.sv | 218 +++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit_if : control, branch-redirect, IMEM and IF/ID signals of the
//                    fetch unit.                                Rev 1.0
// ============================================================================
interface pc_fetch_unit_if #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32
);
    logic                       start;
    logic                       branch_taken;
    logic                       branch_source;
    logic [INST_ADDR_WIDTH-1:0] branch_jalr_target;
    logic [INST_ADDR_WIDTH-1:0] branch_jal_beq_bne_target;
    logic                       stall_id;
    logic                       imem_req;
    logic [INST_ADDR_WIDTH-1:0] imem_addr;
    logic                       imem_gnt;
    logic                       imem_rvalid;
    logic [INST_WIDTH-1:0]      imem_rdata;
    logic [INST_WIDTH-1:0]      inst_IF_ID;
    logic [INST_ADDR_WIDTH-1:0] PC_IF_ID;
    logic                       valid_IF_ID;
    logic                       misalign_err;

    modport master (
        output start, branch_taken, branch_source, branch_jalr_target,
               branch_jal_beq_bne_target, stall_id, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, inst_IF_ID, PC_IF_ID, valid_IF_ID, misalign_err
    );

    modport slave (
        input  start, branch_taken, branch_source, branch_jalr_target,
               branch_jal_beq_bne_target, stall_id, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, inst_IF_ID, PC_IF_ID, valid_IF_ID, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : fetch PC, single-outstanding IMEM requester and IF/ID
//                 register with one-entry skid.  Option macro:
//                 PC_FETCH_MISALIGN_TRAP_EN (trap misaligned redirects). Rev 1.0
// ============================================================================
module pc_fetch_unit #(
    parameter int                         INST_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.slave   bus
);

    localparam logic [INST_ADDR_WIDTH-1:0] c_PC_STEP = INST_ADDR_WIDTH'(4);
    localparam logic [INST_ADDR_WIDTH-1:0] c_BIT0    = INST_ADDR_WIDTH'(1);
    localparam logic [INST_WIDTH-1:0]      c_NOP     = INST_WIDTH'(32'h0000_0013);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        , ST_HALT = 3'd5
`endif
    } state_t;

    state_t                     state_q, state_d;
    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [INST_WIDTH-1:0]      inst_q, inst_d;
    logic [INST_ADDR_WIDTH-1:0] pc_ifid_q, pc_ifid_d;
    logic                       valid_q, valid_d;
    logic [INST_WIDTH-1:0]      skid_inst_q, skid_inst_d;
    logic [INST_ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                       skid_valid_q, skid_valid_d;
    logic                       drop_q, drop_d;

    logic                       w_accept;
    logic                       w_redirect;
    logic                       w_in_flight;
    logic [INST_ADDR_WIDTH-1:0] w_target_raw;
    logic [INST_ADDR_WIDTH-1:0] w_target;

    assign w_accept     = !valid_q || !bus.stall_id;
    assign w_redirect   = bus.branch_taken && valid_q && !bus.stall_id;
    assign w_target_raw = bus.branch_source ? (bus.branch_jalr_target & ~c_BIT0)
                                            : bus.branch_jal_beq_bne_target;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic mis_q, mis_d;
    assign w_target         = w_target_raw;
    assign w_misaligned     = (w_target_raw[1:0] != 2'b00);
    assign bus.misalign_err = mis_q;
`else
    assign w_target         = w_target_raw & ~(c_BIT0 | (c_BIT0 << 1));
    assign bus.misalign_err = 1'b0;
`endif

    // A response is still owed by memory after this edge.
    always_comb begin
        w_in_flight = ((state_q == ST_REQ) && bus.imem_gnt) ||
                      (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !bus.imem_rvalid);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        if ((state_q == ST_HALT) && drop_q && !bus.imem_rvalid) begin
            w_in_flight = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_pc_d     = out_pc_q;
        inst_d       = inst_q;
        pc_ifid_d    = pc_ifid_q;
        valid_d      = valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        drop_d       = drop_q;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        mis_d        = 1'b0;
`endif

        if (valid_q && !bus.stall_id) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.imem_gnt) begin
                    out_pc_d = pc_q;
                    pc_d     = pc_q + c_PC_STEP;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (w_accept) begin
                        inst_d    = bus.imem_rdata;
                        pc_ifid_d = out_pc_q;
                        valid_d   = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        skid_inst_d  = bus.imem_rdata;
                        skid_pc_d    = out_pc_q;
                        skid_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.stall_id && skid_valid_q) begin
                    inst_d       = skid_inst_q;
                    pc_ifid_d    = skid_pc_q;
                    valid_d      = 1'b1;
                    skid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (bus.imem_rvalid) state_d = ST_IDLE;
            end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                if (bus.imem_rvalid) drop_d = 1'b0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides any IF/ID load decided above.
        if (w_redirect) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            inst_d       = inst_q;
            pc_ifid_d    = pc_ifid_q;
            drop_d       = w_in_flight;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
                mis_d   = 1'b1;
                pc_d    = pc_q;
                state_d = ST_HALT;
            end else begin
                pc_d    = w_target;
                state_d = w_in_flight ? ST_WAIT : ST_REQ;
            end
`else
            pc_d    = w_target;
            state_d = w_in_flight ? ST_WAIT : ST_REQ;
`endif
        end

        if (!bus.start) begin
            pc_d         = RESET_PC;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            drop_d       = 1'b0;
            state_d      = w_in_flight ? ST_DRAIN : ST_IDLE;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            mis_d        = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            out_pc_q     <= '0;
            inst_q       <= c_NOP;
            pc_ifid_q    <= '0;
            valid_q      <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_pc_q     <= out_pc_d;
            inst_q       <= inst_d;
            pc_ifid_q    <= pc_ifid_d;
            valid_q      <= valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            drop_q       <= drop_d;
        end
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end
`endif

    assign bus.imem_req    = (state_q == ST_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.inst_IF_ID  = inst_q;
    assign bus.PC_IF_ID    = pc_ifid_q;
    assign bus.valid_IF_ID = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit : directed timing scenarios plus randomized fetch/stall/
//                    redirect traffic checked against a program-order model. Rev 1.0
// ============================================================================
module tb_pc_fetch_unit;

    localparam int             W      = 32;
    localparam int             A      = 32;
    localparam logic [A-1:0]   RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.INST_WIDTH(W), .INST_ADDR_WIDTH(A)) bus ();

    pc_fetch_unit #(.INST_WIDTH(W), .INST_ADDR_WIDTH(A), .RESET_PC(RST_PC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int n_consumed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mem_data(input logic [A-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Architectural target: jalr clears bit 0; without the trap option the
    // word alignment is forced as well.
    function automatic logic [A-1:0] ref_target(input logic src, input logic [A-1:0] jalr,
                                                input logic [A-1:0] jal);
        logic [A-1:0] t;
        t = src ? {jalr[A-1:1], 1'b0} : jal;
`ifndef PC_FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    // ---------------- memory responder ----------------
    int           mem_gnt_pct = 100;
    int           mem_lat_min = 0;
    int           mem_lat_max = 0;
    bit           m_pend      = 1'b0;
    int           m_cnt       = 0;
    logic [A-1:0] m_addr      = '0;

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_data(m_addr);
                    m_pend          = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (rst_n && bus.imem_req === 1'b1) begin
                check("one_outstanding", 64'(m_pend || bus.imem_rvalid), 64'd0);
                if (int'($urandom_range(99, 0)) < mem_gnt_pct) begin
                    bus.imem_gnt = 1'b1;
                    m_pend       = 1'b1;
                    m_addr       = bus.imem_addr;
                    m_cnt        = int'($urandom_range(mem_lat_max, mem_lat_min));
                end
            end
        end
    end

    // ---------------- program-order scoreboard ----------------
    logic [A-1:0] exp_pc = RST_PC;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                exp_pc = RST_PC;
            end else begin
                if (bus.valid_IF_ID && !bus.stall_id) begin
                    check("id_pc_order", 64'(bus.PC_IF_ID), 64'(exp_pc));
                    check("id_inst_data", 64'(bus.inst_IF_ID), 64'(mem_data(bus.PC_IF_ID)));
                    n_consumed++;
                    if (bus.branch_taken)
                        exp_pc = ref_target(bus.branch_source, bus.branch_jalr_target,
                                            bus.branch_jal_beq_bne_target);
                    else
                        exp_pc = exp_pc + 32'd4;
                end
                if (!bus.start) exp_pc = RST_PC;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        check("restart_valid", 64'(bus.valid_IF_ID), 64'd1);
        check("restart_pc", 64'(bus.PC_IF_ID), 64'(RST_PC));
    endtask

    // ---------------- stimulus ----------------
    logic [A-1:0] t_jal;
    logic [A-1:0] t_jalr;

    initial begin
        rst_n                         = 1'b0;
        bus.start                     = 1'b0;
        bus.branch_taken              = 1'b0;
        bus.branch_source             = 1'b0;
        bus.branch_jalr_target        = '0;
        bus.branch_jal_beq_bne_target = '0;
        bus.stall_id                  = 1'b0;
        repeat (3) tick();
        check("rst_req",      64'(bus.imem_req),     64'd0);
        check("rst_addr",     64'(bus.imem_addr),    64'(RST_PC));
        check("rst_inst",     64'(bus.inst_IF_ID),   64'h13);
        check("rst_pc_ifid",  64'(bus.PC_IF_ID),     64'd0);
        check("rst_valid",    64'(bus.valid_IF_ID),  64'd0);
        check("rst_misalign", 64'(bus.misalign_err), 64'd0);
        rst_n = 1'b1;
        tick();

        // Start and zero-wait streaming.
        bus.start = 1'b1;
        tick();
        check("start_req",  64'(bus.imem_req),  64'd1);
        check("start_addr", 64'(bus.imem_addr), 64'(RST_PC));
        tick();
        check("wait_req", 64'(bus.imem_req), 64'd0);
        tick();
        check("first_valid", 64'(bus.valid_IF_ID), 64'd1);
        check("first_pc",    64'(bus.PC_IF_ID),    64'h0);
        check("first_inst",  64'(bus.inst_IF_ID),  64'(mem_data(32'h0)));
        tick();
        check("thru_gap", 64'(bus.valid_IF_ID), 64'd0);
        tick();
        check("second_pc", 64'(bus.PC_IF_ID), 64'h4);

        // ID stall: response parks in the skid, no further requests.
        bus.stall_id = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req",   64'(bus.imem_req),    64'd0);
            check("stall_valid", 64'(bus.valid_IF_ID), 64'd1);
            check("stall_pc",    64'(bus.PC_IF_ID),    64'h4);
        end
        bus.stall_id = 1'b0;
        tick();
        check("skid_valid", 64'(bus.valid_IF_ID), 64'd1);
        check("skid_pc",    64'(bus.PC_IF_ID),    64'h8);
        check("skid_inst",  64'(bus.inst_IF_ID),  64'(mem_data(32'h8)));

        // jal redirect while a slow response is outstanding.
        bus.stall_id = 1'b1;
        mem_lat_min  = 1;
        mem_lat_max  = 1;
        tick();
        check("pre_redir_pc", 64'(bus.PC_IF_ID), 64'h8);
        bus.stall_id                  = 1'b0;
        bus.branch_taken              = 1'b1;
        bus.branch_source             = 1'b0;
        bus.branch_jal_beq_bne_target = 32'h0000_0100;
        bus.branch_jalr_target        = 32'h7777_0000;
        tick();
        bus.branch_taken = 1'b0;
        mem_lat_min      = 0;
        mem_lat_max      = 0;
        check("redir_flush", 64'(bus.valid_IF_ID), 64'd0);
        tick();
        check("redir_nostale", 64'(bus.valid_IF_ID), 64'd0);
        check("redir_req",     64'(bus.imem_req),    64'd1);
        check("redir_addr",    64'(bus.imem_addr),   64'h100);
        tick();
        tick();
        check("redir_valid", 64'(bus.valid_IF_ID), 64'd1);
        check("redir_pc",    64'(bus.PC_IF_ID),    64'h100);
        check("redir_inst",  64'(bus.inst_IF_ID),  64'(mem_data(32'h100)));

        // jalr to an odd, non-word-aligned target.
        bus.branch_taken              = 1'b1;
        bus.branch_source             = 1'b1;
        bus.branch_jalr_target        = 32'h0000_0203;
        bus.branch_jal_beq_bne_target = 32'h5555_0000;
        tick();
        bus.branch_taken = 1'b0;
        check("jalr_flush", 64'(bus.valid_IF_ID), 64'd0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        check("jalr_mis_pulse", 64'(bus.misalign_err), 64'd1);
        tick();
        check("jalr_mis_clear", 64'(bus.misalign_err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("halt_req", 64'(bus.imem_req), 64'd0);
            tick();
        end
`else
        check("jalr_no_mis", 64'(bus.misalign_err), 64'd0);
        tick();
        check("jalr_req",  64'(bus.imem_req),  64'd1);
        check("jalr_addr", 64'(bus.imem_addr), 64'h200);
        tick();
        tick();
        check("jalr_pc", 64'(bus.PC_IF_ID), 64'h200);
`endif
        restart();

        // Sequential wrap past the top of the address space.
        bus.branch_taken              = 1'b1;
        bus.branch_source             = 1'b0;
        bus.branch_jal_beq_bne_target = 32'hFFFF_FFFC;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        check("wrap_top_addr", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_top_pc", 64'(bus.PC_IF_ID),  64'hFFFF_FFFC);
        check("wrap_req",    64'(bus.imem_req),  64'd1);
        check("wrap_addr",   64'(bus.imem_addr), 64'h0);

        // start dropped with a response outstanding: drain before going idle.
        mem_lat_min = 2;
        mem_lat_max = 2;
        tick();
        bus.start = 1'b0;
        tick();
        check("drain_valid", 64'(bus.valid_IF_ID), 64'd0);
        check("drain_req0",  64'(bus.imem_req),    64'd0);
        bus.start   = 1'b1;
        mem_lat_min = 0;
        mem_lat_max = 0;
        tick();
        check("drain_req1", 64'(bus.imem_req), 64'd0);
        tick();
        check("drain_req2", 64'(bus.imem_req), 64'd0);
        tick();
        check("drain_restart_req",  64'(bus.imem_req),  64'd1);
        check("drain_restart_addr", 64'(bus.imem_addr), 64'(RST_PC));

        // Randomized traffic against the program-order scoreboard.
        mem_gnt_pct = 70;
        mem_lat_min = 0;
        mem_lat_max = 3;
        n_consumed  = 0;
        for (int i = 0; i < 3000; i++) begin
            t_jal  = $urandom;
            t_jalr = $urandom;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            t_jal[1:0] = 2'b00;
            t_jalr[1]  = 1'b0;
`endif
            bus.stall_id                  = (int'($urandom_range(99, 0)) < 30);
            bus.branch_taken              = (int'($urandom_range(99, 0)) < 15);
            bus.branch_source             = 1'($urandom_range(1, 0));
            bus.branch_jal_beq_bne_target = t_jal;
            bus.branch_jalr_target        = t_jalr;
            bus.start                     = (int'($urandom_range(99, 0)) >= 2);
            tick();
        end
        bus.stall_id     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.start        = 1'b1;
        repeat (10) tick();
        check("progress", 64'(n_consumed > 150), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
